// File: rtl/stream_loader.sv
// Command-driven stream loader: stages streamed words for the accelerator and
// commits each completed weight row to the selected memory with a one-cycle write.
module stream_loader #(
    parameter int DATA_WIDTH    = 4,
    parameter int COUNTER_WIDTH = 16,
    parameter int X_WORDS       = 768,
    parameter int W_WORDS       = 64,
    parameter int MAX_ADDR_W    = 12,
    parameter int WORD_ADDR_W   = 10,
    parameter int PARK_ADDR     = 2**WORD_ADDR_W - 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_sel,
    input  logic [MAX_ADDR_W-1:0]    cmd_base,
    input  logic [COUNTER_WIDTH-1:0] cmd_rows,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_WIDTH-1:0]    s_data,
    output logic [DATA_WIDTH-1:0]    data_in,
    output logic [WORD_ADDR_W-1:0]   wrd_addr,
    output logic [2:0]               mem_sel,
    output logic [MAX_ADDR_W-1:0]    mem_addr,
    output logic                     mem_en,
    output logic                     mem_wr,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    // state  | meaning
    // IDLE   | waiting for a command, cmd_ready high
    // LOAD   | accepting stream beats into the staging buffer
    // SETTLE | last staged word presented for one cycle
    // WRITE  | one-cycle memory write of the staged row
    // FIN    | done pulse, then back to IDLE
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        WRITE  = 3'd3,
        FIN    = 3'd4
    } state_t;

    localparam int MAX_WORDS = (X_WORDS > W_WORDS) ? X_WORDS : W_WORDS;

    if (PARK_ADDR < MAX_WORDS || PARK_ADDR > 2**WORD_ADDR_W - 1) begin : g_bad_park
        $error("stream_loader: PARK_ADDR must be >= max(X_WORDS, W_WORDS) and fit in WORD_ADDR_W bits");
    end

    localparam logic [2:0]             SEL_X   = 3'd6;
    localparam logic [2:0]             SEL_BAD = 3'd7;
    localparam logic [WORD_ADDR_W-1:0] PARK    = WORD_ADDR_W'(PARK_ADDR);
    localparam logic [WORD_ADDR_W-1:0] X_LAST  = WORD_ADDR_W'(X_WORDS - 1);
    localparam logic [WORD_ADDR_W-1:0] W_LAST  = WORD_ADDR_W'(W_WORDS - 1);
    localparam logic [WORD_ADDR_W-1:0] WORD_ONE = WORD_ADDR_W'(1);
    localparam logic [COUNTER_WIDTH:0] ROW_ONE  = (COUNTER_WIDTH+1)'(1);

    state_t                   state;
    logic                     is_x;
    logic [MAX_ADDR_W-1:0]    base_q;
    logic [COUNTER_WIDTH-1:0] rows_q;
    logic [WORD_ADDR_W-1:0]   word_cnt;
    logic [COUNTER_WIDTH-1:0] row_cnt;

    logic [WORD_ADDR_W-1:0]   last_idx;
    logic [COUNTER_WIDTH:0]   row_nxt;
    logic [MAX_ADDR_W-1:0]    row_off;

    assign last_idx = is_x ? X_LAST : W_LAST;
    assign row_nxt  = {1'b0, row_cnt} + ROW_ONE;
    // Address arithmetic wraps naturally at the memory address width.
    assign row_off  = MAX_ADDR_W'(row_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            data_in   <= '0;
            mem_addr  <= '0;
            mem_sel   <= '0;
            wrd_addr  <= PARK;
            word_cnt  <= '0;
            row_cnt   <= '0;
            is_x      <= 1'b0;
            base_q    <= '0;
            rows_q    <= '0;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            mem_en <= 1'b0;
            mem_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_sel == SEL_BAD) begin
                            err <= 1'b1;
                        end else if (cmd_sel != SEL_X && cmd_rows == '0) begin
                            state     <= FIN;
                            done      <= 1'b1;
                            busy      <= 1'b1;
                            cmd_ready <= 1'b0;
                        end else begin
                            is_x      <= (cmd_sel == SEL_X);
                            base_q    <= cmd_base;
                            rows_q    <= cmd_rows;
                            word_cnt  <= '0;
                            row_cnt   <= '0;
                            mem_sel   <= cmd_sel;
                            state     <= LOAD;
                            s_ready   <= 1'b1;
                            busy      <= 1'b1;
                            cmd_ready <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    if (s_valid && s_ready) begin
                        data_in  <= s_data;
                        wrd_addr <= word_cnt;
                        word_cnt <= word_cnt + WORD_ONE;
                        if (word_cnt == last_idx) begin
                            state   <= SETTLE;
                            s_ready <= 1'b0;
                        end
                    end else begin
                        // Stall cycles park the index so staging is not rewritten.
                        wrd_addr <= PARK;
                    end
                end
                SETTLE: begin
                    wrd_addr <= PARK;
                    if (is_x) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state    <= WRITE;
                        mem_en   <= 1'b1;
                        mem_wr   <= 1'b1;
                        mem_addr <= base_q + row_off;
                    end
                end
                WRITE: begin
                    row_cnt  <= row_nxt[COUNTER_WIDTH-1:0];
                    word_cnt <= '0;
                    if (row_nxt < {1'b0, rows_q}) begin
                        state   <= LOAD;
                        s_ready <= 1'b1;
                    end else begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    s_ready   <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    wrd_addr  <= PARK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_loader.sv
// Bench for stream_loader: table of commands plus random commands, checked by a
// scoreboard that derives staging order, write addresses and timing from the command alone.
module tb_stream_loader;

    localparam int DW    = 4;
    localparam int CW    = 16;
    localparam int XW    = 768;
    localparam int WW    = 64;
    localparam int AW    = 12;
    localparam int WAW   = 10;
    localparam int PARK  = 2**WAW - 1;
    localparam int AMOD  = 2**AW;
    localparam int DMOD  = 2**DW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [2:0]     cmd_sel = 3'd0;
    logic [AW-1:0]  cmd_base = '0;
    logic [CW-1:0]  cmd_rows = '0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [DW-1:0]  s_data = '0;
    logic [DW-1:0]  data_in;
    logic [WAW-1:0] wrd_addr;
    logic [2:0]     mem_sel;
    logic [AW-1:0]  mem_addr;
    logic           mem_en;
    logic           mem_wr;
    logic           busy;
    logic           done;
    logic           err;

    stream_loader dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_base(cmd_base), .cmd_rows(cmd_rows),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .data_in(data_in), .wrd_addr(wrd_addr), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_en(mem_en), .mem_wr(mem_wr), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int wa; int d; } stage_t;
    typedef struct { int addr; int sel; int wr; int cyc; } wr_t;

    stage_t stage_q[$];
    wr_t    wr_q[$];
    int     done_q[$];
    int     err_q[$];
    int     beat_q[$];
    int     beat_cyc_q[$];
    int     viol = 0;

    // Observer: samples mid-cycle, records everything the DUT presents.
    always @(negedge clk) begin
        if (!rst) begin
            if (int'(wrd_addr) != PARK) stage_q.push_back('{int'(wrd_addr), int'(data_in)});
            if (mem_en) wr_q.push_back('{int'(mem_addr), int'(mem_sel), int'(mem_wr), cyc});
            if (done) done_q.push_back(cyc);
            if (err) err_q.push_back(cyc);
            if (s_valid && s_ready) begin
                beat_q.push_back(int'(s_data));
                beat_cyc_q.push_back(cyc);
            end
            if ((cmd_ready && (busy || s_ready)) || (mem_en != mem_wr) ||
                (mem_en && int'(wrd_addr) != PARK) || (s_ready && !busy) || (done && err))
                viol++;
        end
    end

    int valid_pct  = 0;
    int beat_start = 0;
    bit rand_data  = 1'b0;

    always @(posedge clk) begin
        #1;
        s_valid = ($urandom_range(99) < valid_pct);
        if (rand_data) s_data = DW'($urandom);
        else           s_data = DW'(beat_q.size() - beat_start);
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset(input string name);
        logic [35:0] act;
        logic [35:0] exp;
        act = {cmd_ready, s_ready, busy, done, err, mem_en, mem_wr, data_in, mem_addr, mem_sel, wrd_addr};
        exp = {1'b1, 6'b0, 4'd0, 12'd0, 3'd0, 10'(PARK)};
        check(name, longint'(act), longint'(exp));
    endtask

    int cur_msel   = 0;
    int last_waddr = 0;

    task automatic run_cmd(input string tag, input int sel, input int base, input int rows,
                           input int pct, input bit rnd, input int exp_writes,
                           input bit exp_err, input int exp_done);
        int s0, w0, d0, e0, b0, acc, n_words, rows_eff, bad, exp_n, dcyc;
        bit fin;
        n_words  = (sel == 6) ? XW : WW;
        rows_eff = (sel == 7) ? 0 : ((sel == 6) ? 1 : rows);
        exp_n    = n_words * rows_eff;
        step();
        check({tag, " cmd_ready_idle"}, cmd_ready, 1);
        s0 = stage_q.size(); w0 = wr_q.size(); d0 = done_q.size(); e0 = err_q.size();
        b0 = beat_q.size();
        valid_pct  = pct;
        rand_data  = rnd;
        beat_start = b0;
        cmd_valid  = 1'b1;
        cmd_sel    = 3'(sel);
        cmd_base   = AW'(base);
        cmd_rows   = CW'(rows);
        acc        = cyc;
        step();
        cmd_valid = 1'b0;
        fin = 1'b0;
        for (int k = 0; k < 20000 && !fin; k++) begin
            step();
            if (done_q.size() > d0 || err_q.size() > e0) fin = 1'b1;
        end
        check({tag, " completes"}, fin, 1);
        repeat (2) step();

        check({tag, " err_pulses"}, err_q.size() - e0, exp_err);
        check({tag, " done_pulses"}, done_q.size() - d0, exp_done);
        check({tag, " write_pulses"}, wr_q.size() - w0, exp_writes);
        check({tag, " beats"}, beat_q.size() - b0, exp_n);

        bad = (stage_q.size() - s0 != exp_n) ? 1 : 0;
        for (int j = 0; j < exp_n && s0 + j < stage_q.size(); j++) begin
            int ed;
            if (!rnd) ed = j % DMOD;
            else if (b0 + j < beat_q.size()) ed = beat_q[b0 + j];
            else ed = -1;
            if (stage_q[s0 + j].wa != j % n_words || stage_q[s0 + j].d != ed) bad++;
        end
        check({tag, " staging_seq_mismatches"}, bad, 0);

        bad = 0;
        for (int r = 0; r < exp_writes && w0 + r < wr_q.size(); r++) begin
            if (wr_q[w0 + r].addr != (base + r) % AMOD || wr_q[w0 + r].sel != sel ||
                wr_q[w0 + r].wr != 1) bad++;
            if (pct >= 100 && wr_q[w0 + r].cyc != acc + (WW + 2) * (r + 1)) bad++;
        end
        check({tag, " write_addr_timing_mismatches"}, bad, 0);

        if (exp_err) check({tag, " err_cycle"}, (err_q.size() > e0) ? err_q[e0] - acc : -1, 1);

        if (exp_done == 1 && (pct >= 100 || rows_eff == 0)) begin
            dcyc = (done_q.size() > d0) ? done_q[d0] - acc : -1;
            if (sel == 6)      check({tag, " done_cycle"}, dcyc, XW + 2);
            else if (rows == 0) check({tag, " done_cycle"}, dcyc, 1);
            else               check({tag, " done_cycle"}, dcyc, (WW + 2) * rows + 1);
            if (sel == 6)
                check({tag, " done_after_last_beat"},
                      (done_q.size() > d0 && beat_q.size() > b0) ? done_q[d0] - beat_cyc_q[beat_q.size() - 1] : -1, 2);
        end

        if (sel != 7 && !(sel < 6 && rows == 0)) cur_msel = sel;
        check({tag, " idle_after"}, {busy, cmd_ready, s_ready, mem_en, done}, 5'b01000);
        check({tag, " mem_sel_held"}, mem_sel, cur_msel);
        if (exp_err) check({tag, " mem_addr_unchanged"}, mem_addr, last_waddr);
        if (sel < 6 && rows > 0) last_waddr = (base + rows - 1) % AMOD;
    endtask

    typedef struct {
        int sel; int base; int rows; int pct; int exp_writes; bit exp_err; int exp_done;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int w0, d0;
        bit reached;
        vecs[0] = '{6,    0, 5, 100, 0, 1'b0, 1};
        vecs[1] = '{2,   10, 3, 100, 3, 1'b0, 1};
        vecs[2] = '{5, 4095, 2, 100, 2, 1'b0, 1};
        vecs[3] = '{3,  100, 1,  50, 1, 1'b0, 1};
        vecs[4] = '{7,  300, 2, 100, 0, 1'b1, 0};
        vecs[5] = '{1,    7, 0, 100, 0, 1'b0, 1};
        vecs[6] = '{0, 2000, 2,  70, 2, 1'b0, 1};
        vecs[7] = '{4, 4094, 3,  40, 3, 1'b0, 1};

        repeat (3) @(posedge clk);
        #2;
        check_reset("reset_initial");
        rst = 1'b0;
        step();
        check_reset("idle_after_release");

        // Reset in the middle of row 0 must abandon the row without a write.
        step();
        w0 = wr_q.size(); d0 = done_q.size();
        valid_pct = 100; rand_data = 1'b0; beat_start = beat_q.size();
        cmd_valid = 1'b1; cmd_sel = 3'd2; cmd_base = AW'(10); cmd_rows = CW'(2);
        step();
        cmd_valid = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 200 && !reached; k++) begin
            if (beat_q.size() - beat_start >= 30) reached = 1'b1;
            else step();
        end
        check("rst_mid reached_beat_30", reached, 1);
        #1 rst = 1'b1;
        #1 check_reset("rst_mid same_cycle");
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        check("rst_mid no_write", wr_q.size() - w0, 0);
        check("rst_mid no_done", done_q.size() - d0, 0);
        check_reset("rst_mid after_release");
        cur_msel = 0;
        last_waddr = 0;

        for (int i = 0; i < 8; i++)
            run_cmd($sformatf("vec%0d", i), vecs[i].sel, vecs[i].base, vecs[i].rows, vecs[i].pct,
                    1'b0, vecs[i].exp_writes, vecs[i].exp_err, vecs[i].exp_done);

        for (int i = 0; i < 5; i++) begin
            int sel, base, rows, pct;
            sel  = $urandom_range(7);
            base = $urandom_range(AMOD - 1);
            rows = $urandom_range(3);
            pct  = $urandom_range(30, 100);
            run_cmd($sformatf("rnd%0d", i), sel, base, rows, pct, 1'b1,
                    (sel < 6) ? rows : 0, sel == 7, (sel == 7) ? 0 : 1);
        end

        check("invariant_violations", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stream_loader.md
STREAM_LOADER -- requirements
Module: stream_loader

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 4, word width; COUNTER_WIDTH, default 16, row counter width; X_WORDS, default 768, activation words per X load; W_WORDS, default 64, words per weight row; MAX_ADDR_W, default 12, memory address width; WORD_ADDR_W, default 10, staging word index width; PARK_ADDR, default 2**WORD_ADDR_W-1, idle word index.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_sel  in  3  target select; 6 = X staging, 0-5 = weight memories, 7 = illegal.
REQ-007 cmd_base  in  MAX_ADDR_W  first memory row address.
REQ-008 cmd_rows  in  COUNTER_WIDTH  number of rows to write; ignored for cmd_sel 6.
REQ-009 s_valid / s_ready / s_data  in / out / in  1 / 1 / DATA_WIDTH  word stream; a beat transfers when s_valid && s_ready.
REQ-010 data_in, wrd_addr, mem_sel, mem_addr, mem_en, mem_wr  out  DATA_WIDTH, WORD_ADDR_W, 3, MAX_ADDR_W, 1, 1  staging and memory-write port to the downstream accelerator top; all registered.
REQ-011 busy  out  1  high from command acceptance until done.
REQ-012 done  out  1  one-cycle pulse at command completion.
REQ-013 err  out  1  one-cycle pulse on illegal command.

Function
REQ-014 PARK_ADDR SHALL be >= max(X_WORDS, W_WORDS); the design SHALL fail elaboration otherwise.
REQ-015 The state machine SHALL have the states IDLE, LOAD, SETTLE, WRITE and FIN.
REQ-016 In IDLE, cmd_ready SHALL be 1; every other state SHALL hold cmd_ready at 0.
REQ-017 On acceptance with cmd_sel 7: err pulse next cycle, stay IDLE, no output change.
REQ-018 On acceptance with cmd_sel 0-5 and cmd_rows = 0: go to FIN, with no stream beats and no write.
REQ-019 On any other acceptance: latch sel, base and rows; clear word_cnt and row_cnt; drive mem_sel = sel; go to LOAD.
REQ-020 s_ready SHALL be 1 only in LOAD.
REQ-021 A beat accepted in cycle t SHALL appear on data_in, with wrd_addr = word_cnt, in cycle t+1; word_cnt then increments.
REQ-022 Gaps in s_valid SHALL stall LOAD without changing word_cnt.
REQ-023 On the beat with word_cnt = N-1 (N = X_WORDS for sel 6, else W_WORDS): go to SETTLE, which presents the last word for one cycle.
REQ-024 After SETTLE, sel 6 SHALL go to FIN; other selects SHALL go to WRITE.
REQ-025 WRITE SHALL last one cycle with mem_en = mem_wr = 1, mem_addr = (base + row_cnt) mod 2**MAX_ADDR_W, and wrd_addr = PARK_ADDR.
REQ-026 After WRITE, row_cnt SHALL increment and word_cnt SHALL clear; go to LOAD if row_cnt+1 < rows, else to FIN.
REQ-027 FIN SHALL pulse done for one cycle, clear busy and return to IDLE; mem_sel SHALL hold its value.
REQ-028 Outside LOAD-driven and SETTLE cycles, wrd_addr SHALL equal PARK_ADDR, so the downstream staging is never overwritten.
REQ-029 mem_en and mem_wr SHALL be 0 in every state except WRITE.
REQ-030 With s_valid held high, a row SHALL take W_WORDS+2 cycles and rows SHALL be back-to-back.

Reset
REQ-031 rst SHALL immediately force: IDLE, cmd_ready=1, s_ready=0, busy=0, done=0, err=0, mem_en=0, mem_wr=0, data_in=0, mem_addr=0, mem_sel=0, wrd_addr=PARK_ADDR, counters=0.
REQ-032 Reset mid-command SHALL abandon the command with no write pulse; the partial row SHALL NOT be written.

Verification
REQ-033 X load: cmd_sel=6, 768 beats of value i mod 16 with s_valid continuous -> wrd_addr 0..767 in order with matching data_in, one SETTLE cycle, done 2 cycles after the last beat, no mem_en.
REQ-034 Weights: cmd_sel=2, base=10, rows=3, continuous stream -> mem_en pulses at mem_addr 10, 11, 12, spaced 66 cycles apart, with mem_sel=2 throughout, then done.
REQ-035 Wrap: base=4095, rows=2 -> write addresses 4095 then 0.
REQ-036 Backpressure: random s_valid gaps, rows=1 -> identical wrd_addr/data_in sequence, exactly one write pulse, wrd_addr=PARK_ADDR in gap cycles.
REQ-037 Corner commands: cmd_sel=7 -> err pulse only; cmd_sel=1 with rows=0 -> done pulse with no write; assert rst at beat 30 of row 0 -> no mem_en, and all outputs at reset values in the same cycle.
